mips_multicycle: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS top.
- Executes each instruction over a FETCH/DECODE/EXEC/MEM/WB state machine.
- Talks to external instruction and data memories over req/ack handshakes, so wait-state memories are supported.
- Adds jump, halt-on-illegal-opcode, a configurable reset PC and debug/retire outputs.

---
 rtl/mips_multicycle.sv | 250 +++++++++++++++++++++++++
 tb/tb_mips_multicycle.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over
// req/ack instruction and data memories, with jump, halt-on-illegal and debug outputs.
module mips_multicycle #(
   parameter int unsigned IM_AW    = 10,
   parameter int unsigned DM_AW    = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [IM_AW-1:0] imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [DM_AW-1:0] dmem_addr,
   output logic [31:0]      dmem_wdata,
   input  logic [31:0]      dmem_rdata,
   input  logic             dmem_ack,
   output logic             retire,
   output logic [31:0]      pc_dbg,
   output logic             halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   state_t             stateQ, stateD;
   logic [31:0]        pcQ, pcD;
   logic [31:0]        irQ, irD;
   logic [31:0]        aQ, aD;
   logic [31:0]        bQ, bD;
   logic [DM_AW-1:0]   memAddrQ, memAddrD;
   logic [31:0]        mdrQ, mdrD;
   logic [31:0]        regsQ [32];

   logic               wrEn;
   logic [4:0]         wrAddr;
   logic [31:0]        wrData;
   logic               fetchReq;

   logic [5:0]         op;
   logic [4:0]         rs, rt, rd;
   logic [5:0]         funct;
   logic [15:0]        imm;
   logic [31:0]        immZ, immS;
   logic               isRtype, isOri, isLw, isSw, isBeq, isBne, isJ;
   logic               legalFunct, legal;
   logic [31:0]        aluResult;
   logic [31:0]        branchTarget;

   assign op      = irQ[31:26];
   assign rs      = irQ[25:21];
   assign rt      = irQ[20:16];
   assign rd      = irQ[15:11];
   assign funct   = irQ[5:0];
   assign imm     = irQ[15:0];
   assign immZ    = {16'h0000, imm};
   assign immS    = {{16{imm[15]}}, imm};

   assign isRtype = (op == OP_RTYPE);
   assign isOri   = (op == OP_ORI);
   assign isLw    = (op == OP_LW);
   assign isSw    = (op == OP_SW);
   assign isBeq   = (op == OP_BEQ);
   assign isBne   = (op == OP_BNE);
   assign isJ     = (op == OP_J);

   // pcQ already points past the branch, so the target is pcQ + (offset << 2).
   assign branchTarget = pcQ + {immS[29:0], 2'b00};

   always_comb begin
      legalFunct = 1'b0;
      case (funct)
         FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: legalFunct = 1'b1;
         default:                                 legalFunct = 1'b0;
      endcase
   end

   assign legal = (isRtype && legalFunct) || isOri || isLw || isSw || isBeq || isBne || isJ;

   // Single ALU shared by R-type, ori and load/store address generation.
   always_comb begin
      aluResult = '0;
      if (isRtype) begin
         case (funct)
            FN_ADDU: aluResult = aQ + bQ;
            FN_SUBU: aluResult = aQ - bQ;
            FN_AND:  aluResult = aQ & bQ;
            FN_OR:   aluResult = aQ | bQ;
            FN_SLT:  aluResult = {31'b0, ($signed(aQ) < $signed(bQ))};
            default: aluResult = '0;
         endcase
      end else if (isOri) begin
         aluResult = aQ | immZ;
      end else begin
         aluResult = aQ + immS;
      end
   end

   always_comb begin
      stateD   = stateQ;
      pcD      = pcQ;
      irD      = irQ;
      aD       = aQ;
      bD       = bQ;
      memAddrD = memAddrQ;
      mdrD     = mdrQ;
      wrEn     = 1'b0;
      wrAddr   = rt;
      wrData   = aluResult;
      retire   = 1'b0;
      fetchReq = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;

      case (stateQ)
         S_FETCH: begin
            fetchReq = 1'b1;
            if (imem_ack) begin
               irD    = imem_rdata;
               pcD    = pcQ + 32'd4;
               stateD = S_DECODE;
            end
         end

         S_DECODE: begin
            aD = regsQ[rs];
            bD = regsQ[rt];
            if (isJ) begin
               pcD    = {pcQ[31:28], irQ[25:0], 2'b00};
               retire = 1'b1;
               stateD = S_FETCH;
            end else if (!legal) begin
               stateD = S_HALT;
            end else begin
               stateD = S_EXEC;
            end
         end

         S_EXEC: begin
            if (isRtype || isOri) begin
               wrEn   = 1'b1;
               wrAddr = isRtype ? rd : rt;
               retire = 1'b1;
               stateD = S_FETCH;
            end else if (isBeq || isBne) begin
               if ((aQ == bQ) == isBeq) begin
                  pcD = branchTarget;
               end
               retire = 1'b1;
               stateD = S_FETCH;
            end else begin
               memAddrD = aluResult[DM_AW+1:2];
               stateD   = S_MEM;
            end
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = isSw;
            if (dmem_ack) begin
               if (isSw) begin
                  retire = 1'b1;
                  stateD = S_FETCH;
               end else begin
                  mdrD   = dmem_rdata;
                  stateD = S_WB;
               end
            end
         end

         S_WB: begin
            wrEn   = 1'b1;
            wrAddr = rt;
            wrData = mdrQ;
            retire = 1'b1;
            stateD = S_FETCH;
         end

         S_HALT: begin
            stateD = S_HALT;
         end

         default: begin
            stateD = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ   <= S_FETCH;
         pcQ      <= RESET_PC;
         irQ      <= '0;
         aQ       <= '0;
         bQ       <= '0;
         memAddrQ <= '0;
         mdrQ     <= '0;
      end else begin
         stateQ   <= stateD;
         pcQ      <= pcD;
         irQ      <= irD;
         aQ       <= aD;
         bQ       <= bD;
         memAddrQ <= memAddrD;
         mdrQ     <= mdrD;
      end
   end

   // $0 is never written, so it keeps its reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regsQ[i] <= '0;
         end
      end else if (wrEn && (wrAddr != 5'd0)) begin
         regsQ[wrAddr] <= wrData;
      end
   end

   // The reset state is FETCH, so the request is masked while reset is held.
   assign imem_req   = fetchReq & rst;
   assign imem_addr  = pcQ[IM_AW+1:2];
   assign dmem_addr  = memAddrQ;
   assign dmem_wdata = bQ;
   assign pc_dbg     = (stateQ == S_FETCH) ? pcQ : (pcQ - 32'd4);
   assign halted     = (stateQ == S_HALT);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs run against wait-state
// memory models, with retire timing, fetch order and stored results checked.
module tb_mips_multicycle;

   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;
   localparam logic [31:0] FILL    = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ack = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic        retire;
   logic [31:0] pc_dbg;
   logic        halted;

   logic [31:0] imem [0:1023];
   logic [31:0] dmem [0:1023];

   int imemWait = 0;
   int dmemWait = 0;
   int imemCnt = 0;
   int dmemCnt = 0;
   int cycle = 0;
   int imemReqCount = 0;
   int retireQ [$];
   int fetchQ [$];

   int compareCount = 0;
   int mismatchCount = 0;

   mips_multicycle #(
      .IM_AW(10),
      .DM_AW(10),
      .RESET_PC(32'h0000_0100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .imem_ack(imem_ack),
      .dmem_req(dmem_req),
      .dmem_we(dmem_we),
      .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack),
      .retire(retire),
      .pc_dbg(pc_dbg),
      .halted(halted)
   );

   always #5 clk = ~clk;

   // Memory models answer on the falling edge after the programmed number of
   // wait cycles, then record retire pulses once the core outputs have settled.
   always @(negedge clk) begin
      if (!rst) begin
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         imemCnt  = 0;
         dmemCnt  = 0;
         cycle    = 0;
      end else begin
         cycle++;
         if (imem_req) begin
            imemReqCount++;
            if (imemCnt >= imemWait) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
               fetchQ.push_back(int'(imem_addr));
               imemCnt    = 0;
            end else begin
               imem_ack = 1'b0;
               imemCnt++;
            end
         end else begin
            imem_ack = 1'b0;
            imemCnt  = 0;
         end
         if (dmem_req) begin
            if (dmemCnt >= dmemWait) begin
               dmem_ack = 1'b1;
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               else         dmem_rdata = dmem[dmem_addr];
               dmemCnt  = 0;
            end else begin
               dmem_ack = 1'b0;
               dmemCnt++;
            end
         end else begin
            dmem_ack = 1'b0;
            dmemCnt  = 0;
         end
         #1;
         if (retire) retireQ.push_back(cycle);
      end
   end

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] jtype(input logic [25:0] idx);
      return {6'h02, idx};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic clearMems();
      for (int i = 0; i < 1024; i++) begin
         imem[i] = ILLEGAL;
         dmem[i] = FILL;
      end
   endtask

   // Holds reset for two cycles, optionally checks the reset outputs, then releases it.
   task automatic applyStimulus(input int iw, input int dw, input bit checkReset);
      rst = 1'b0;
      imemWait = iw;
      dmemWait = dw;
      retireQ.delete();
      fetchQ.delete();
      imemReqCount = 0;
      repeat (2) @(posedge clk);
      #1;
      if (checkReset) begin
         checkOutput("reset_imem_req", {31'b0, imem_req}, 32'd0);
         checkOutput("reset_dmem_req", {31'b0, dmem_req}, 32'd0);
         checkOutput("reset_dmem_we", {31'b0, dmem_we}, 32'd0);
         checkOutput("reset_retire", {31'b0, retire}, 32'd0);
         checkOutput("reset_halted", {31'b0, halted}, 32'd0);
      end
      rst = 1'b1;
   endtask

   task automatic waitHalted(input int budget, input string tag);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!halted) checkOutput(tag, 32'd0, 32'd1);
   endtask

   task automatic waitRetires(input int count, input int budget);
      int n = 0;
      while (retireQ.size() < count && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (retireQ.size() < count) checkOutput("retire_timeout", retireQ.size(), count);
   endtask

   task automatic waitFetches(input int count, input int budget);
      int n = 0;
      while (fetchQ.size() < count && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (fetchQ.size() < count) checkOutput("fetch_timeout", fetchQ.size(), count);
   endtask

   function automatic int retireAt(input int i);
      return (i < retireQ.size()) ? retireQ[i] : -1;
   endfunction

   initial begin
      int expRetire [5];
      int expFetch [12];
      expRetire = '{3, 6, 9, 12, 15};
      expFetch  = '{'h40, 'h41, 'h42, 'h43, 'h42, 'h43, 'h44, 'h45, 'h46, 'h47, 'h48, 'h40};

      // Arithmetic program with zero-wait memories; results are stored for inspection.
      clearMems();
      imem[64] = itype(6'h0D, 5'd0, 5'd1, 16'd5);
      imem[65] = itype(6'h0D, 5'd0, 5'd2, 16'd7);
      imem[66] = rtype(5'd1, 5'd2, 5'd3, 6'h21);
      imem[67] = rtype(5'd1, 5'd2, 5'd4, 6'h23);
      imem[68] = rtype(5'd4, 5'd1, 5'd5, 6'h2A);
      imem[69] = itype(6'h2B, 5'd0, 5'd3, 16'd0);
      imem[70] = itype(6'h2B, 5'd0, 5'd4, 16'd4);
      imem[71] = itype(6'h2B, 5'd0, 5'd5, 16'd8);
      imem[72] = itype(6'h2B, 5'd0, 5'd7, 16'd12);
      applyStimulus(0, 0, 1'b1);
      @(negedge clk);
      #2;
      checkOutput("first_imem_req", {31'b0, imem_req}, 32'd1);
      checkOutput("first_imem_addr", {22'b0, imem_addr}, 32'h40);
      checkOutput("first_pc_dbg", pc_dbg, 32'h100);
      waitHalted(300, "arith_halt_timeout");
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("arith_retire_cycle%0d", i), retireAt(i), expRetire[i]);
      end
      checkOutput("arith_retire_total", retireQ.size(), 32'd9);
      checkOutput("addu_result", dmem[0], 32'd12);
      checkOutput("subu_result", dmem[1], 32'hFFFF_FFFE);
      checkOutput("slt_result", dmem[2], 32'd1);
      checkOutput("unwritten_reg", dmem[3], 32'd0);
      checkOutput("halt_pc_dbg", pc_dbg, 32'h124);
      rst = 1'b0;
      #1;
      checkOutput("reset_clears_halt", {31'b0, halted}, 32'd0);

      // Store then load with two data-memory wait cycles.
      clearMems();
      imem[64] = itype(6'h0D, 5'd0, 5'd3, 16'd12);
      imem[65] = itype(6'h2B, 5'd0, 5'd3, 16'd8);
      imem[66] = itype(6'h23, 5'd0, 5'd6, 16'd8);
      imem[67] = itype(6'h2B, 5'd0, 5'd6, 16'h20);
      applyStimulus(0, 2, 1'b0);
      waitHalted(300, "mem_halt_timeout");
      checkOutput("sw_word2_data", dmem[2], 32'd12);
      checkOutput("lw_result", dmem[8], 32'd12);
      checkOutput("sw_wait_latency", retireAt(1) - retireAt(0), 32'd6);
      checkOutput("lw_wait_latency", retireAt(2) - retireAt(1), 32'd7);
      checkOutput("lw_retire_cycle", retireAt(2), 32'd16);

      // Branch loop, untaken bne, write to $0 and jump, with one fetch wait cycle.
      clearMems();
      imem[64] = itype(6'h0D, 5'd0, 5'd1, 16'd2);
      imem[65] = itype(6'h0D, 5'd0, 5'd3, 16'd1);
      imem[66] = rtype(5'd1, 5'd3, 5'd1, 6'h23);
      imem[67] = itype(6'h04, 5'd1, 5'd3, 16'hFFFE);
      imem[68] = itype(6'h05, 5'd1, 5'd0, 16'd5);
      imem[69] = rtype(5'd3, 5'd3, 5'd0, 6'h21);
      imem[70] = itype(6'h2B, 5'd0, 5'd0, 16'h30);
      imem[71] = itype(6'h2B, 5'd0, 5'd1, 16'h34);
      imem[72] = jtype(26'h40);
      applyStimulus(1, 0, 1'b0);
      waitRetires(11, 400);
      waitFetches(12, 50);
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("branch_fetch%0d", i),
                     (i < fetchQ.size()) ? fetchQ[i] : -1, expFetch[i]);
      end
      checkOutput("fetch_wait_retire", retireAt(0), 32'd4);
      checkOutput("reg0_reads_zero", dmem[12], 32'd0);
      checkOutput("loop_counter", dmem[13], 32'd0);

      // Illegal opcode halts after decode and stops issuing fetches.
      clearMems();
      applyStimulus(0, 0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         #2;
      end
      checkOutput("halted_in_decode", {31'b0, halted}, 32'd0);
      @(negedge clk);
      #2;
      checkOutput("halted_after_decode", {31'b0, halted}, 32'd1);
      repeat (10) @(negedge clk);
      #2;
      checkOutput("halt_fetch_count", imemReqCount, 32'd1);
      checkOutput("halt_no_retire", retireQ.size(), 32'd0);
      checkOutput("halt_pc_dbg_illegal", pc_dbg, 32'h100);
      rst = 1'b0;
      #1;
      checkOutput("illegal_reset_clears", {31'b0, halted}, 32'd0);

      // Reset during a load wait state aborts it; a follow-up program reads $6 back.
      clearMems();
      dmem[2]  = 32'h55;
      imem[64] = itype(6'h23, 5'd0, 5'd6, 16'd8);
      applyStimulus(0, 5, 1'b0);
      repeat (5) begin
         @(negedge clk);
         #2;
      end
      checkOutput("mem_wait_req", {31'b0, dmem_req}, 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("abort_dmem_req", {31'b0, dmem_req}, 32'd0);
      checkOutput("abort_retire", {31'b0, retire}, 32'd0);
      imem[64] = itype(6'h2B, 5'd0, 5'd6, 16'h40);
      applyStimulus(0, 0, 1'b0);
      @(negedge clk);
      #2;
      checkOutput("abort_restart_addr", {22'b0, imem_addr}, 32'h40);
      waitHalted(100, "abort_halt_timeout");
      checkOutput("abort_reg_unchanged", dmem[16], 32'd0);
      checkOutput("abort_retire_total", retireQ.size(), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
